// File: rtl/sqrt_post_stage.sv
// Post-processing stage for the 8-bit integer square-root pipeline: aligns valid,
// derives remainder / rounded root / exact / error, and queues results in a FWFT FIFO.
module sqrt_post_stage #(
    parameter int LAT   = 4,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [3:0]    root_c,
    input  logic [7:0]    x_orig,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    out_root,
    output logic [4:0]    out_rem,
    output logic [4:0]    out_rnd,
    output logic          out_exact,
    output logic          out_err,
    output logic [CW-1:0] fifo_count,
    output logic          overflow,
    output logic [7:0]    drop_cnt
);

    // Handshake: a head entry transfers on any posedge where out_valid && out_ready;
    // out_valid never depends on out_ready, and out_ready while empty has no effect.

    logic [LAT-1:0] vdly;
    logic           v_al;

    always_ff @(posedge clk) begin
        if (rst) begin
            vdly <= '0;
        end else begin
            vdly <= {vdly[LAT-2:0], in_valid};
        end
    end

    assign v_al = vdly[LAT-1];

    logic [7:0] sq;
    logic [8:0] d;
    logic       err_c;
    logic [4:0] rem_c;
    logic [4:0] rnd_c;
    logic       exact_c;

    assign sq = {4'd0, root_c} * {4'd0, root_c};
    assign d  = {1'b0, x_orig} - {1'b0, sq};

    // A remainder above 30 cannot come from a true floor root of an 8-bit value.
    assign err_c   = d[8] || (d > 9'd30);
    assign rem_c   = err_c ? 5'd0 : d[4:0];
    assign rnd_c   = {1'b0, root_c} + {4'd0, (rem_c > {1'b0, root_c})};
    assign exact_c = !err_c && (rem_c == 5'd0);

    logic        r_valid;
    logic [15:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= v_al;
            r_data  <= {err_c, exact_c, rnd_c, rem_c, root_c};
        end
    end

    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic          drop;
    logic [15:0]   head;

    assign full      = (count == CW'(DEPTH));
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    // A simultaneous pop frees the slot, so a full FIFO can still accept.
    assign push_ok   = r_valid && (!full || pop);
    assign drop      = r_valid && full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= r_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end

    assign head       = out_valid ? mem[rd_ptr] : 16'd0;
    assign out_root   = head[3:0];
    assign out_rem    = head[8:4];
    assign out_rnd    = head[13:9];
    assign out_exact  = head[14];
    assign out_err    = head[15];
    assign fifo_count = count;

endmodule

// File: tb/tb_sqrt_post_stage.sv
// Directed bench for sqrt_post_stage with a behavioural 4-cycle root pipeline in front
// and an expected-queue scoreboard on the output handshake.
module tb_sqrt_post_stage;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] root_c;
    logic [7:0] x_orig;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_root;
    logic [4:0] out_rem;
    logic [4:0] out_rnd;
    logic       out_exact;
    logic       out_err;
    logic [2:0] fifo_count;
    logic       overflow;
    logic [7:0] drop_cnt;

    sqrt_post_stage #(.LAT(4), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .root_c(root_c), .x_orig(x_orig),
        .out_valid(out_valid), .out_ready(out_ready), .out_root(out_root),
        .out_rem(out_rem), .out_rnd(out_rnd), .out_exact(out_exact), .out_err(out_err),
        .fifo_count(fifo_count), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // behavioural root pipeline: X driven in cycle t appears at its outputs in cycle t+4
    logic [7:0] x_in;
    logic       force_en;
    logic [3:0] force_c;
    logic [7:0] px [4];
    logic [3:0] pc [4];

    function automatic logic [3:0] isqrt(input logic [7:0] x);
        logic [3:0] r;
        r = 4'd0;
        for (int k = 1; k < 16; k++) begin
            if (k * k <= int'(x)) r = 4'(k);
        end
        return r;
    endfunction

    always @(posedge clk) begin
        px[0] <= x_in;
        pc[0] <= force_en ? force_c : isqrt(x_in);
        for (int i = 1; i < 4; i++) begin
            px[i] <= px[i-1];
            pc[i] <= pc[i-1];
        end
    end

    assign root_c = pc[3];
    assign x_orig = px[3];

    // scoreboard
    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pack(input logic err, input logic exact,
                                         input logic [4:0] rnd, input logic [4:0] rem,
                                         input logic [3:0] root);
        return {err, exact, rnd, rem, root};
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", 32'd1, 32'd0);
            end else begin
                check("head", {16'd0, out_err, out_exact, out_rnd, out_rem, out_root},
                      {16'd0, exp_q.pop_front()});
            end
        end
    end

    // driver tasks (all called at posedge+1)
    task automatic send(input logic [7:0] x, input logic fe, input logic [3:0] fc,
                        output int t0);
        t0       = cyc;
        x_in     = x;
        force_en = fe;
        force_c  = fc;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        force_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic go_to(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 60) begin
            @(posedge clk); #1;
            guard++;
        end
        check(tag, exp_q.size(), 0);
        idle(2);
    endtask

    task automatic wait_valid(output int c);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        if (!out_valid) check("wait_valid_timeout", 32'd0, 32'd1);
        c = cyc;
    endtask

    int t0, t1, tv;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        x_in = 8'd0; force_en = 1'b0; force_c = 4'd0;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_data", {out_err, out_exact, out_rnd, out_rem, out_root}, 0);
        @(posedge clk); #1;

        // 1: X=200, latency 6
        out_ready = 1'b1;
        exp_q.push_back(pack(0, 0, 5'd14, 5'd4, 4'd14));
        send(8'd200, 1'b0, 4'd0, t0);
        wait_valid(tv);
        check("lat_200", tv - t0, 6);
        #1;
        drain("drain_t1");

        // 2: X=255 then X=0 back to back, consecutive outputs
        exp_q.push_back(pack(0, 0, 5'd16, 5'd30, 4'd15));
        exp_q.push_back(pack(0, 1, 5'd0, 5'd0, 4'd0));
        send(8'd255, 1'b0, 4'd0, t0);
        send(8'd0, 1'b0, 4'd0, t1);
        wait_valid(tv);
        check("lat_255", tv - t0, 6);
        @(negedge clk);
        check("consec_valid", out_valid, 1);
        #1;
        drain("drain_t2");

        // 3: rounding boundary and perfect square
        exp_q.push_back(pack(0, 0, 5'd9, 5'd9, 4'd9));
        exp_q.push_back(pack(0, 0, 5'd10, 5'd10, 4'd9));
        exp_q.push_back(pack(0, 1, 5'd15, 5'd0, 4'd15));
        send(8'd90, 1'b0, 4'd0, t0);
        send(8'd91, 1'b0, 4'd0, t0);
        send(8'd225, 1'b0, 4'd0, t0);
        drain("drain_t3");

        // 4: stalled consumer, 6 samples -> 4 kept, 2 dropped
        out_ready = 1'b0;
        exp_q.push_back(pack(0, 0, 5'd14, 5'd4, 4'd14));
        exp_q.push_back(pack(0, 0, 5'd16, 5'd30, 4'd15));
        exp_q.push_back(pack(0, 1, 5'd0, 5'd0, 4'd0));
        exp_q.push_back(pack(0, 0, 5'd9, 5'd9, 4'd9));
        send(8'd200, 1'b0, 4'd0, t0);
        send(8'd255, 1'b0, 4'd0, t0);
        send(8'd0, 1'b0, 4'd0, t0);
        send(8'd90, 1'b0, 4'd0, t0);
        send(8'd91, 1'b0, 4'd0, t0);
        send(8'd225, 1'b0, 4'd0, t0);
        idle(10);
        @(negedge clk);
        check("full_count", fifo_count, 4);
        check("full_overflow", overflow, 1);
        check("full_drop_cnt", drop_cnt, 2);
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain("drain_t4");
        check("empty_count", fifo_count, 0);

        // 5: full FIFO, pop and push in the same cycle
        out_ready = 1'b0;
        exp_q.push_back(pack(0, 0, 5'd14, 5'd4, 4'd14));
        exp_q.push_back(pack(0, 0, 5'd16, 5'd30, 4'd15));
        exp_q.push_back(pack(0, 1, 5'd0, 5'd0, 4'd0));
        exp_q.push_back(pack(0, 0, 5'd9, 5'd9, 4'd9));
        exp_q.push_back(pack(0, 0, 5'd10, 5'd10, 4'd9));
        exp_q.push_back(pack(0, 1, 5'd15, 5'd0, 4'd15));
        send(8'd200, 1'b0, 4'd0, t0);
        send(8'd255, 1'b0, 4'd0, t0);
        send(8'd0, 1'b0, 4'd0, t0);
        send(8'd90, 1'b0, 4'd0, t0);
        idle(4);
        send(8'd91, 1'b0, 4'd0, t1);
        send(8'd225, 1'b0, 4'd0, t0);
        go_to(t1 + 5);
        out_ready = 1'b1;
        @(negedge clk);
        check("pp_count_pre", fifo_count, 4);
        @(negedge clk);
        check("pp_count_1", fifo_count, 4);
        @(negedge clk);
        check("pp_count_2", fifo_count, 4);
        check("pp_no_drop", drop_cnt, 2);
        #1;
        drain("drain_t5");

        // 6: inconsistent root, then reset with samples in flight
        exp_q.push_back(pack(1, 0, 5'd15, 5'd0, 4'd15));
        send(8'd100, 1'b1, 4'd15, t0);
        wait_valid(tv);
        check("err_flag", out_err, 1);
        check("err_rem", out_rem, 0);
        #1;
        drain("drain_t6");
        send(8'd10, 1'b0, 4'd0, t0);
        send(8'd20, 1'b0, 4'd0, t0);
        send(8'd30, 1'b0, 4'd0, t0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tv = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) tv++;
        end
        check("flush_no_valid", tv, 0);
        check("flush_count", fifo_count, 0);
        check("flush_overflow", overflow, 0);
        check("flush_drop_cnt", drop_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
